sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO with separate write and read enables, so a read and a write can happen in the same cycle. It has a registered read port, occupancy count, programmable almost-full/almost-empty thresholds, and one-cycle overflow/underflow pulses. It is the general-purpose buffer between producer and consumer stages in the datapath.

Parameters:
DATA_W, 32, width of the data word in bits
DEPTH, 8, number of entries; power of two, at least 2
AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
wr_en  in  1  write request
wr_data  in  DATA_W  data to write
rd_en  in  1  read request
rd_data  out  DATA_W  registered read data
rd_valid  out  1  high for one cycle when rd_data holds a newly read word
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  out  1  one-cycle pulse: write rejected
underflow  out  1  one-cycle pulse: read rejected

Behaviour:
- Pointers and count:
  - Storage is DEPTH x DATA_W.
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - count is a separate register.
- Accept rules, evaluated on pre-edge state:
  - rd_acc = rd_en && !empty
  - wr_acc = wr_en && (!full || rd_en)
  - Write while full is accepted only when a read happens in the same cycle; the entry freed by the read is reused.
- Write: on wr_acc, mem[wr_ptr] <= wr_data and wr_ptr increments.
- Read latency is 1 cycle:
  - On rd_acc, rd_data <= mem[rd_ptr], rd_ptr increments, and rd_valid <= 1.
  - Otherwise rd_valid <= 0 and rd_data holds its last value.
- count update:
  - +1 when wr_acc only.
  - -1 when rd_acc only.
  - Unchanged when both or neither.
  - Never exceeds DEPTH and never goes below 0.
- Simultaneous read and write when empty: the write is accepted, the read is rejected (underflow pulses), and count becomes 1. There is no bypass; the word becomes readable on the next cycle.
- Simultaneous read and write when full: both are accepted and count stays DEPTH.
- Flags (full, empty, almost_full, almost_empty) are combinational decodes of the count register, so they change in the cycle after the causing edge.
- Error pulses:
  - overflow <= wr_en && !wr_acc.
  - underflow <= rd_en && !rd_acc.
  - Both are registered and high for exactly one cycle per rejected request.
  - A rejected request has no other effect.
- Reset (rst sampled high at a clock edge):
  - Pointers and count go to 0; rd_data goes to 0.
  - rd_valid, overflow and underflow go to 0.
  - Therefore empty=1, full=0, almost_empty=1, and almost_full=0 unless AF_LEVEL has no valid setting.
  - Memory contents are not cleared.
- Reset mid-operation: rst has priority over all requests in that cycle, and stored data is discarded.
- Elaboration checks (fatal): DEPTH not a power of two, or AF_LEVEL/AE_LEVEL out of range.
- No $display or $error in synthesizable code; assertions go in a separate bind file.

Decomposition:
- Package sync_fifo_pkg holds:
  - the default DATA_W/DEPTH constants;
  - a function computing the count width;
  - a typedef for the status bundle (full, empty, almost_full, almost_empty).
- One sub-module, fifo_mem_2p: DEPTH x DATA_W array with a synchronous write port and a registered read port. Pointer, count and flag control stays in sync_fifo_param.

Test Plan:
- Reset, then write 8 words 0x10..0x17 on consecutive cycles with defaults:
  - count reaches 8 and full=1.
  - almost_full rises when count reaches 6.
  - A 9th write gives overflow=1 for one cycle, and count stays 8.
- Read the 8 words back-to-back:
  - rd_data is 0x10..0x17 in order, each one cycle after its rd_en, with rd_valid high.
  - empty=1 afterwards.
  - One more read gives underflow=1 and rd_valid=0.
- Wrap-around: repeat 20 cycles of write-4 / read-4:
  - data stays in order across the pointer wrap;
  - count returns to 0 each iteration.
- Simultaneous read and write:
  - When full: both accepted, count stays 8, no overflow, and the order is preserved.
  - When empty: count becomes 1, underflow pulses, and the written word is read on the next read.
- Assert rst after 5 writes:
  - next cycle count=0, empty=1, rd_valid=0;
  - a subsequent read gives underflow.
  - Then write 0xA5 and read it: rd_data=0xA5.
- Reconfigure to DATA_W=16, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1:
  - almost_empty holds for count 0..1;
  - almost_full asserts at count 3;
  - full asserts at count 4.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared constants and types for the parametrised synchronous FIFO.
package sync_fifo_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 8;

  // Occupancy needs one extra bit so that a completely full FIFO (DEPTH) is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

endpackage

// File: rtl/fifo_mem_2p.sv
// DEPTH x DATA_W storage: synchronous write port, registered read port.
module fifo_mem_2p #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Array is left unreset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_param_sva.sv
// Protocol assertions for sync_fifo_param, attached to every instance by bind.
module sync_fifo_param_sva #(
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input logic          clk,
  input logic          rst,
  input logic          wr_en,
  input logic          rd_en,
  input logic          full,
  input logic          empty,
  input logic          overflow,
  input logic          underflow,
  input logic [CW-1:0] count
);

  a_count_max: assert property (@(posedge clk) disable iff (rst) count <= CW'(DEPTH));
  a_flags_ex:  assert property (@(posedge clk) disable iff (rst) !(full && empty));
  a_ovf_src:   assert property (@(posedge clk) disable iff (rst)
                                overflow |-> $past(wr_en && full && !rd_en));
  a_udf_src:   assert property (@(posedge clk) disable iff (rst)
                                underflow |-> $past(rd_en && empty));

endmodule

bind sync_fifo_param sync_fifo_param_sva #(
  .DEPTH (DEPTH),
  .CW    ($clog2(DEPTH) + 1)
) u_sva (
  .clk       (clk),
  .rst       (rst),
  .wr_en     (wr_en),
  .rd_en     (rd_en),
  .full      (full),
  .empty     (empty),
  .overflow  (overflow),
  .underflow (underflow),
  .count     (count)
);

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with independent read/write enables, registered read data,
// occupancy count, programmable almost-full/almost-empty and error pulses.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      rd_en,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      rd_valid,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "sync_fifo_param: DEPTH must be a power of two >= 2");
  end
  if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
    $fatal(1, "sync_fifo_param: AF_LEVEL out of range 1..DEPTH");
  end
  if ((AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1)) begin : g_bad_ae
    $fatal(1, "sync_fifo_param: AE_LEVEL out of range 0..DEPTH-1");
  end

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          rd_acc, wr_acc;
  fifo_status_t  st;

  always_comb begin
    st              = '0;
    st.full         = (count == CW'(DEPTH));
    st.empty        = (count == '0);
    st.almost_full  = (count >= CW'(AF_LEVEL));
    st.almost_empty = (count <= CW'(AE_LEVEL));
  end

  assign full         = st.full;
  assign empty        = st.empty;
  assign almost_full  = st.almost_full;
  assign almost_empty = st.almost_empty;

  // A write into a full FIFO is legal when a read frees a slot in the same edge.
  assign rd_acc = rd_en && !st.empty;
  assign wr_acc = wr_en && (!st.full || rd_en);

  fifo_mem_2p #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc && !rst),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .re    (rd_acc && !rst),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      rd_valid  <= rd_acc;
      overflow  <= wr_en && !wr_acc;
      underflow <= rd_en && !rd_acc;
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: directed vector table, corner sequences, randomized
// traffic against a queue model, and a small DEPTH=4 configuration.
module tb_sync_fifo_param;

  localparam int D  = 8;
  localparam int AF = 6;
  localparam int AE = 2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Default configuration
  logic        rst = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [31:0] wr_data = '0, rd_data;
  logic        rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0]  count;

  sync_fifo_param dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  // Small configuration
  logic        s_rst = 1'b1, s_wr_en = 1'b0, s_rd_en = 1'b0;
  logic [15:0] s_wr_data = '0, s_rd_data;
  logic        s_rd_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic [2:0]  s_count;

  sync_fifo_param #(.DATA_W(16), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) dut_s (
    .clk(clk), .rst(s_rst), .wr_en(s_wr_en), .wr_data(s_wr_data), .rd_en(s_rd_en),
    .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
    .overflow(s_ovf), .underflow(s_udf)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: contents as a queue, last delivered word as a scalar.
  logic [31:0] mq[$];
  logic [31:0] m_data = '0;

  task automatic step(input bit r, input bit w, input logic [31:0] wd, input bit rd);
    bit ra, wa, ev, eo, eu;
    rst = r; wr_en = w; wr_data = wd; rd_en = rd;
    ev = 0; eo = 0; eu = 0;
    if (r) begin
      mq.delete();
      m_data = '0;
    end else begin
      ra = rd && (mq.size() > 0);
      wa = w && ((mq.size() < D) || rd);
      ev = ra;
      eo = w && !wa;
      eu = rd && !ra;
      if (ra) m_data = mq.pop_front();
      if (wa) mq.push_back(wd);
    end
    @(posedge clk); #1;
    rst = 0; wr_en = 0; rd_en = 0;
    chk("count",        count,        mq.size());
    chk("full",         full,         mq.size() == D);
    chk("empty",        empty,        mq.size() == 0);
    chk("almost_full",  almost_full,  mq.size() >= AF);
    chk("almost_empty", almost_empty, mq.size() <= AE);
    chk("rd_valid",     rd_valid,     ev);
    chk("rd_data",      rd_data,      m_data);
    chk("overflow",     overflow,     eo);
    chk("underflow",    underflow,    eu);
  endtask

  typedef struct {
    bit          r, w, rd;
    logic [31:0] wd;
    int          cnt;
    bit          f, e, af, ae, vld, ovf, udf;
    logic [31:0] data;
  } vec_t;

  function automatic vec_t mk(bit r, bit w, bit rd, logic [31:0] wd, int cnt,
                              bit f, bit e, bit af, bit ae, bit vld, bit ovf, bit udf,
                              logic [31:0] data);
    vec_t v;
    v.r = r; v.w = w; v.rd = rd; v.wd = wd; v.cnt = cnt;
    v.f = f; v.e = e; v.af = af; v.ae = ae; v.vld = vld; v.ovf = ovf; v.udf = udf;
    v.data = data;
    return v;
  endfunction

  task automatic s_step(input bit r, input bit w, input logic [15:0] wd, input bit rd);
    s_rst = r; s_wr_en = w; s_wr_data = wd; s_rd_en = rd;
    @(posedge clk); #1;
    s_rst = 0; s_wr_en = 0; s_rd_en = 0;
  endtask

  task automatic s_flags(input int c);
    bit ae_t[5] = '{1, 1, 0, 0, 0};
    bit af_t[5] = '{0, 0, 0, 1, 1};
    bit f_t[5]  = '{0, 0, 0, 0, 1};
    chk($sformatf("s count@%0d", c),        s_count, c);
    chk($sformatf("s almost_empty@%0d", c), s_ae,    ae_t[c]);
    chk($sformatf("s almost_full@%0d", c),  s_af,    af_t[c]);
    chk($sformatf("s full@%0d", c),         s_full,  f_t[c]);
    chk($sformatf("s empty@%0d", c),        s_empty, c == 0);
  endtask

  initial begin
    vec_t vt[$];
    //           r w rd wd     cnt f e af ae vld ovf udf data
    vt.push_back(mk(1,0,0, 32'h0,  0, 0,1,0,1, 0,0,0, 32'h0));
    vt.push_back(mk(0,1,0, 32'h10, 1, 0,0,0,1, 0,0,0, 32'h0));
    vt.push_back(mk(0,1,0, 32'h11, 2, 0,0,0,1, 0,0,0, 32'h0));
    vt.push_back(mk(0,1,0, 32'h12, 3, 0,0,0,0, 0,0,0, 32'h0));
    vt.push_back(mk(0,1,0, 32'h13, 4, 0,0,0,0, 0,0,0, 32'h0));
    vt.push_back(mk(0,1,0, 32'h14, 5, 0,0,0,0, 0,0,0, 32'h0));
    vt.push_back(mk(0,1,0, 32'h15, 6, 0,0,1,0, 0,0,0, 32'h0));
    vt.push_back(mk(0,1,0, 32'h16, 7, 0,0,1,0, 0,0,0, 32'h0));
    vt.push_back(mk(0,1,0, 32'h17, 8, 1,0,1,0, 0,0,0, 32'h0));
    vt.push_back(mk(0,1,0, 32'h18, 8, 1,0,1,0, 0,1,0, 32'h0));
    vt.push_back(mk(0,0,0, 32'h0,  8, 1,0,1,0, 0,0,0, 32'h0));
    vt.push_back(mk(0,0,1, 32'h0,  7, 0,0,1,0, 1,0,0, 32'h10));
    vt.push_back(mk(0,0,1, 32'h0,  6, 0,0,1,0, 1,0,0, 32'h11));
    vt.push_back(mk(0,0,1, 32'h0,  5, 0,0,0,0, 1,0,0, 32'h12));
    vt.push_back(mk(0,0,1, 32'h0,  4, 0,0,0,0, 1,0,0, 32'h13));
    vt.push_back(mk(0,0,1, 32'h0,  3, 0,0,0,0, 1,0,0, 32'h14));
    vt.push_back(mk(0,0,1, 32'h0,  2, 0,0,0,1, 1,0,0, 32'h15));
    vt.push_back(mk(0,0,1, 32'h0,  1, 0,0,0,1, 1,0,0, 32'h16));
    vt.push_back(mk(0,0,1, 32'h0,  0, 0,1,0,1, 1,0,0, 32'h17));
    vt.push_back(mk(0,0,1, 32'h0,  0, 0,1,0,1, 0,0,1, 32'h17));

    foreach (vt[i]) begin
      step(vt[i].r, vt[i].w, vt[i].wd, vt[i].rd);
      chk($sformatf("vec%0d count", i),     count,        vt[i].cnt);
      chk($sformatf("vec%0d full", i),      full,         vt[i].f);
      chk($sformatf("vec%0d empty", i),     empty,        vt[i].e);
      chk($sformatf("vec%0d af", i),        almost_full,  vt[i].af);
      chk($sformatf("vec%0d ae", i),        almost_empty, vt[i].ae);
      chk($sformatf("vec%0d rd_valid", i),  rd_valid,     vt[i].vld);
      chk($sformatf("vec%0d overflow", i),  overflow,     vt[i].ovf);
      chk($sformatf("vec%0d underflow", i), underflow,    vt[i].udf);
      chk($sformatf("vec%0d rd_data", i),   rd_data,      vt[i].data);
    end

    // Pointer wrap: 20 rounds of write-4 / read-4
    for (int it = 0; it < 20; it++) begin
      for (int k = 0; k < 4; k++) step(0, 1, $urandom, 0);
      for (int k = 0; k < 4; k++) step(0, 0, 32'h0, 1);
      chk($sformatf("wrap%0d count", it), count, 0);
    end

    // Simultaneous read/write while full
    for (int k = 0; k < D; k++) step(0, 1, 32'hA0 + k, 0);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 32'hC0 + k, 1);
      chk("sim full count", count, D);
      chk("sim full ovf", overflow, 0);
      chk("sim full data", rd_data, 32'hA0 + k);
    end
    for (int k = 0; k < D; k++) step(0, 0, 32'h0, 1);
    chk("sim full last", rd_data, 32'hC3);

    // Simultaneous read/write while empty
    step(0, 1, 32'hE1, 1);
    chk("sim empty udf", underflow, 1);
    chk("sim empty count", count, 1);
    step(0, 0, 32'h0, 1);
    chk("sim empty data", rd_data, 32'hE1);
    chk("sim empty vld", rd_valid, 1);

    // Reset mid-operation, with requests present in the reset cycle
    for (int k = 0; k < 5; k++) step(0, 1, 32'h50 + k, 0);
    step(1, 1, 32'h99, 1);
    chk("rst count", count, 0);
    chk("rst empty", empty, 1);
    chk("rst rd_valid", rd_valid, 0);
    step(0, 0, 32'h0, 1);
    chk("rst udf", underflow, 1);
    step(0, 1, 32'hA5, 0);
    step(0, 0, 32'h0, 1);
    chk("rst a5", rd_data, 32'hA5);

    // Randomized traffic, alternating fill-biased and drain-biased phases
    for (int n = 0; n < 600; n++) begin
      int wp;
      wp = ((n / 100) % 2) ? 70 : 30;
      step($urandom_range(0, 99) == 0, $urandom_range(0, 99) < wp, $urandom,
           $urandom_range(0, 99) < (100 - wp));
    end

    // Small configuration: flag thresholds and data order
    s_step(1, 0, 16'h0, 0);
    s_flags(0);
    for (int k = 0; k < 4; k++) begin
      s_step(0, 1, 16'hB000 + 16'(k), 0);
      s_flags(k + 1);
    end
    s_step(0, 1, 16'hBEEF, 0);
    chk("s overflow", s_ovf, 1);
    s_flags(4);
    for (int k = 0; k < 4; k++) begin
      s_step(0, 0, 16'h0, 1);
      chk($sformatf("s data%0d", k), s_rd_data, 16'hB000 + 16'(k));
      chk($sformatf("s vld%0d", k), s_rd_valid, 1);
      s_flags(3 - k);
    end
    s_step(0, 0, 16'h0, 1);
    chk("s underflow", s_udf, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
